msk_pattern_checker: RTL
========================

Name: msk_pattern_checker

Overview:
- Synthesizable multi-channel bit-pattern checker for MSK receiver demod outputs, e.g. the timing-loop slicer, oversampled demod and CFO-corrected slicer paths.
- Each lane acquires frame alignment against a repeating fixed pattern and tracks lock. It counts checked bits and bit errors, and drops lock on excessive errors.
- Replaces simulation-only pattern viewing with a counter-based BER monitor usable on hardware and in the bench.

Parameters:
- NCH, 3: number of independent lanes.
- FDW, 256: pattern length in bits.
- FIXED_DATA, 256'h9010...a50ffe: repeating pattern, transmitted MSB first.
- SYNC_W, 32: acquisition word length; the first SYNC_W MSBs of FIXED_DATA. Must be ≤ FDW and unique within the cyclic pattern.
- LOSS_WIN, 64: lock-monitor window length in checked bits.
- LOSS_THR, 8: errors within one window that force loss of lock.
- CNT_W, 32: width of the bit and error counters.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- data_i, in, NCH: received bit per lane.
- data_val_i, in, NCH: per-lane bit strobe; a lane may strobe on any cycle.
- clr_i, in, 1: synchronous clear of all counters; lock state is unaffected.
- locked_o, out, NCH: lane is in LOCK.
- err_o, out, NCH: one-cycle pulse on a mismatched bit while in LOCK.
- bit_cnt_o, out, NCH*CNT_W: bits checked while in LOCK (lane k at [k*CNT_W +: CNT_W]).
- err_cnt_o, out, NCH*CNT_W: bit errors while in LOCK.
- loss_cnt_o, out, NCH*16: number of LOCK→SEARCH transitions.

Behaviour:
- Reset: all outputs 0; every lane in SEARCH; shift registers, pointers and window counters 0.
- Per lane, a SYNC_W-bit history shift register updates on every valid bit: new bit enters the LSB.
- State machine per lane:
  - SEARCH: on a valid bit, if the updated history equals FIXED_DATA[FDW-1 -: SYNC_W] → LOCK. Pointer set to SYNC_W mod FDW; window counters cleared. locked_o rises the cycle after that strobe (1-cycle latency).
  - LOCK: each valid bit is compared with FIXED_DATA[FDW-1-ptr]. Pointer increments and wraps FDW-1 → 0. bit_cnt increments; on mismatch err_cnt increments and err_o pulses the next cycle.
  - Window: a LOSS_WIN bit counter and a window error counter run in LOCK.
    - If window errors reach LOSS_THR (evaluated including the current bit) → SEARCH next cycle; loss_cnt increments; history is retained so reacquisition can occur on the very next valid bit.
    - Otherwise, when the window count completes, both window counters reset.
- All counters saturate at all-ones; no wrap.
- clr_i with a simultaneous increment: clear wins, so the counter becomes 0, not 1.
- rst with clr_i or data: rst wins.
- Lanes are fully independent; no cross-lane interaction.
- No back-pressure. Bits arriving with data_val_i low are ignored.

Optional Feature:
- Macro MSK_PATCHK_INV_EN.
- Defined:
  - SEARCH also matches the bitwise-inverted sync word, covering MSK phase ambiguity.
  - On an inverted match the lane latches an invert flag and compares ~data_i thereafter. The flag clears on entry to SEARCH.
  - Adds output port inv_o, out, NCH, per-lane invert flag; reset 0.
- Undefined: only the true sync word is matched; no inv_o port.

Decomposition:
- Package msk_patchk_pkg holds:
  - typedef lane_state_t {SEARCH, LOCK};
  - localparam LOSS_CNT_W = 16;
  - function sync_word() returning the SYNC_W MSBs of the pattern.
- Sub-module msk_patchk_lane: one lane containing the FSM, pointer and counters. The top uses a generate loop over NCH and packs outputs.

Test Plan:
- Default parameters; lane 0 fed the repeating pattern, one bit per 20 clk → locked_o[0] rises after bit 32. After 4 periods (1024 bits): bit_cnt = 992, err_cnt = 0.
- In LOCK, flip 3 bits spaced 10 bits apart → 3 err_o pulses; err_cnt = 3; lock held; loss_cnt = 0.
- In LOCK, flip 8 consecutive bits → locked_o falls the cycle after the 8th error; loss_cnt = 1. Reacquires on the next sync word: locked_o high again.
- Lane 1 fed random bits, lane 2 the pattern, both with simultaneous strobes → lane 2 locks, lane 1 stays in SEARCH with bit_cnt = 0. Then pulse clr_i coincident with a lane 2 bit → lane 2 bit_cnt = 0.
- Set CNT_W = 4 (CNT_W is a parameter), run 40 locked bits → bit_cnt saturates at 15.
- With MSK_PATCHK_INV_EN, feed the inverted pattern → lock, inv_o = 1, err_cnt = 0. Without the macro → no lock.

Source files
------------

// File: rtl/msk_patchk_pkg.sv
// Shared types and defaults for the MSK bit-pattern checker.
// The sync word is the leading slice of the repeating pattern.
package msk_patchk_pkg;

    localparam int DEF_FDW    = 256;
    localparam int DEF_SYNC_W = 32;
    localparam int LOSS_CNT_W = 16;

    localparam logic [DEF_FDW-1:0] DEF_FIXED_DATA =
        256'h9010_3c5a_e7b2_4d81_6f29_c3a4_5e17_b80d_2c6b_f193_7a48_05de_91c7_3b6e_84a5_0ffe;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCK   = 1'b1
    } lane_state_t;

    function automatic logic [DEF_SYNC_W-1:0] sync_word();
        return DEF_FIXED_DATA[DEF_FDW-1 -: DEF_SYNC_W];
    endfunction

endpackage

// File: rtl/msk_patchk_lane.sv
// One checker lane: sync search, locked compare, loss-of-lock window.
// MSK_PATCHK_INV_EN also accepts the inverted sync word (phase ambiguity).
module msk_patchk_lane
    import msk_patchk_pkg::*;
#(
    parameter int              FDW        = DEF_FDW,
    parameter logic [FDW-1:0]  FIXED_DATA = DEF_FIXED_DATA,
    parameter int              SYNC_W     = DEF_SYNC_W,
    parameter int              LOSS_WIN   = 64,
    parameter int              LOSS_THR   = 8,
    parameter int              CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_i,
    input  logic                  data_val_i,
    input  logic                  clr_i,
    output logic                  locked_o,
    output logic                  err_o,
`ifdef MSK_PATCHK_INV_EN
    output logic                  inv_o,
`endif
    output logic [CNT_W-1:0]      bit_cnt_o,
    output logic [CNT_W-1:0]      err_cnt_o,
    output logic [LOSS_CNT_W-1:0] loss_cnt_o
);

    localparam int PW = (FDW > 1) ? $clog2(FDW) : 1;
    localparam int WW = $clog2(LOSS_WIN + 1);
    localparam int EW = $clog2(LOSS_THR + 1);

    localparam logic [SYNC_W-1:0] SYNC     = FIXED_DATA[FDW-1 -: SYNC_W];
    localparam logic [PW-1:0]     PTR_INIT = PW'(SYNC_W % FDW);
    localparam logic [PW-1:0]     PTR_LAST = PW'(FDW - 1);
    localparam logic [WW-1:0]     WIN_LAST = WW'(LOSS_WIN - 1);
    localparam logic [EW-1:0]     THR      = EW'(LOSS_THR);

    lane_state_t           state_q, state_d;
    logic [SYNC_W-1:0]     hist_q, hist_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [WW-1:0]         win_q, win_d;
    logic [EW-1:0]         werr_q, werr_d, werr_nx;
    logic                  inv_q, inv_d;
    logic                  err_q, err_d;
    logic                  bit_inc, err_inc, loss_inc;
    logic [PW-1:0]         idx;
    logic                  rx_bit, mism;
    logic [CNT_W-1:0]      bit_cnt_q, err_cnt_q;
    logic [LOSS_CNT_W-1:0] loss_cnt_q;

    assign idx     = PTR_LAST - ptr_q;
    assign rx_bit  = data_i ^ inv_q;
    assign mism    = rx_bit ^ FIXED_DATA[idx];
    assign werr_nx = werr_q + EW'(mism);

    // Next-state: history shift, acquisition, pointer and window tracking
    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        werr_d   = werr_q;
        inv_d    = inv_q;
        err_d    = 1'b0;
        bit_inc  = 1'b0;
        err_inc  = 1'b0;
        loss_inc = 1'b0;
        if (data_val_i) begin
            hist_d = {hist_q[SYNC_W-2:0], data_i};
            unique case (state_q)
                SEARCH: begin
                    if (hist_d == SYNC) begin
                        state_d = LOCK;
                        ptr_d   = PTR_INIT;
                        win_d   = '0;
                        werr_d  = '0;
                        inv_d   = 1'b0;
`ifdef MSK_PATCHK_INV_EN
                    end else if (hist_d == ~SYNC) begin
                        state_d = LOCK;
                        ptr_d   = PTR_INIT;
                        win_d   = '0;
                        werr_d  = '0;
                        inv_d   = 1'b1;
`endif
                    end
                end
                LOCK: begin
                    bit_inc = 1'b1;
                    err_inc = mism;
                    err_d   = mism;
                    ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
                    if (werr_nx >= THR) begin
                        state_d  = SEARCH;
                        loss_inc = 1'b1;
                        inv_d    = 1'b0;
                        win_d    = '0;
                        werr_d   = '0;
                    end else if (win_q == WIN_LAST) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d  = win_q + 1'b1;
                        werr_d = werr_nx;
                    end
                end
            endcase
        end
    end

    // Lane state register and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEARCH;
            hist_q  <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            werr_q  <= '0;
            inv_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            werr_q  <= werr_d;
            inv_q   <= inv_d;
            err_q   <= err_d;
        end
    end

    // Saturating statistics counters; clear beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            bit_cnt_q  <= '0;
            err_cnt_q  <= '0;
            loss_cnt_q <= '0;
        end else begin
            if (bit_inc && !(&bit_cnt_q))
                bit_cnt_q <= bit_cnt_q + 1'b1;
            if (err_inc && !(&err_cnt_q))
                err_cnt_q <= err_cnt_q + 1'b1;
            if (loss_inc && !(&loss_cnt_q))
                loss_cnt_q <= loss_cnt_q + 1'b1;
        end
    end

    assign locked_o   = (state_q == LOCK);
    assign err_o      = err_q;
    assign bit_cnt_o  = bit_cnt_q;
    assign err_cnt_o  = err_cnt_q;
    assign loss_cnt_o = loss_cnt_q;
`ifdef MSK_PATCHK_INV_EN
    assign inv_o      = inv_q;
`endif

endmodule

// File: rtl/msk_pattern_checker.sv
// Multi-lane BER monitor for MSK demod outputs; one lane per input.
// Optional MSK_PATCHK_INV_EN adds inverted-sync acquisition and inv_o.
module msk_pattern_checker
    import msk_patchk_pkg::*;
#(
    parameter int             NCH        = 3,
    parameter int             FDW        = DEF_FDW,
    parameter logic [FDW-1:0] FIXED_DATA = DEF_FIXED_DATA,
    parameter int             SYNC_W     = DEF_SYNC_W,
    parameter int             LOSS_WIN   = 64,
    parameter int             LOSS_THR   = 8,
    parameter int             CNT_W      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCH-1:0]            data_i,
    input  logic [NCH-1:0]            data_val_i,
    input  logic                      clr_i,
    output logic [NCH-1:0]            locked_o,
    output logic [NCH-1:0]            err_o,
`ifdef MSK_PATCHK_INV_EN
    output logic [NCH-1:0]            inv_o,
`endif
    output logic [NCH*CNT_W-1:0]      bit_cnt_o,
    output logic [NCH*CNT_W-1:0]      err_cnt_o,
    output logic [NCH*LOSS_CNT_W-1:0] loss_cnt_o
);

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        msk_patchk_lane #(
            .FDW        (FDW),
            .FIXED_DATA (FIXED_DATA),
            .SYNC_W     (SYNC_W),
            .LOSS_WIN   (LOSS_WIN),
            .LOSS_THR   (LOSS_THR),
            .CNT_W      (CNT_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .data_i     (data_i[k]),
            .data_val_i (data_val_i[k]),
            .clr_i      (clr_i),
            .locked_o   (locked_o[k]),
            .err_o      (err_o[k]),
`ifdef MSK_PATCHK_INV_EN
            .inv_o      (inv_o[k]),
`endif
            .bit_cnt_o  (bit_cnt_o[k*CNT_W +: CNT_W]),
            .err_cnt_o  (err_cnt_o[k*CNT_W +: CNT_W]),
            .loss_cnt_o (loss_cnt_o[k*LOSS_CNT_W +: LOSS_CNT_W])
        );
    end

endmodule
